// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: run control, jump redirect, program-load port and decode-facing outputs.
// Latency: none (wires only).
// Backpressure: stall travels master->slave; no ready is returned.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  // control / redirect
  logic              start;
  logic              stall;
  logic              jump;
  logic              jump_abs;
  logic [ADDR_W-1:0] jmpammt;
  // program-load byte port
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_data;
  // fetch results towards decode
  logic [ADDR_W-1:0] PC;
  logic [31:0]       Instruction_Code;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              fault;

  // driver side (sequencer / loader / decode)
  modport master (
    output start, stall, jump, jump_abs, jmpammt,
    output prog_we, prog_addr, prog_data,
    input  PC, Instruction_Code, instr_pc, instr_valid, fault
  );

  // fetch unit side
  modport slave (
    input  start, stall, jump, jump_abs, jmpammt,
    input  prog_we, prog_addr, prog_data,
    output PC, Instruction_Code, instr_pc, instr_valid, fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: PC, big-endian byte instruction memory with load port, jump/squash, IDLE/RUN/FAULT control.
// Latency: instruction at PC p is registered on the edge closing the cycle in which PC==p (one edge).
// Backpressure: stall holds PC and all outputs; jump overrides stall; fault is sticky until reset.
module instr_fetch_unit #(
  parameter int                MEM_BYTES = 64,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.slave  bus
);

  localparam int                IDX_W   = $clog2(MEM_BYTES);
  // memory size widened by one bit so pc+3 can be range-checked without wrapping
  localparam logic [ADDR_W:0]   MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic [7:0]        mem_q [MEM_BYTES];

  logic [ADDR_W:0]   pc_last;
  logic              pc_bad;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_word;
  logic [ADDR_W-1:0] jump_tgt;
  logic              wr_ok;
  logic [IDX_W-1:0]  wr_idx;

  // last byte of the word at pc, computed one bit wider so a pc near 2^ADDR_W cannot alias into range
  assign pc_last = {1'b0, pc_q} + (ADDR_W+1)'(3);
  assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_last >= MEM_LIM);

  // big-endian word: lowest address is the most significant byte
  assign rd_idx  = pc_q[IDX_W-1:0];
  assign rd_word = {mem_q[rd_idx],
                    mem_q[rd_idx + IDX_W'(1)],
                    mem_q[rd_idx + IDX_W'(2)],
                    mem_q[rd_idx + IDX_W'(3)]};

  // relative targets are modulo 2^ADDR_W; wrapped targets are trapped by pc_bad next cycle
  assign jump_tgt = bus.jump_abs ? bus.jmpammt : (pc_q + ADDR_W'(4) + bus.jmpammt);

  // out-of-range load addresses are dropped rather than aliased onto low memory
  assign wr_ok  = bus.prog_we && ({1'b0, bus.prog_addr} < MEM_LIM);
  assign wr_idx = bus.prog_addr[IDX_W-1:0];

  // program-load write; independent of reset so images can be loaded while the core is held
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_idx] <= bus.prog_data;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: start leaves IDLE, a bad PC traps into FAULT, only reset leaves FAULT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (pc_bad)    state_d = S_FAULT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath next values: fault check, then jump (squash), then stall, then fetch
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
      end
      S_RUN: begin
        if (pc_bad) begin
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (bus.jump) begin
          pc_d    = jump_tgt;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d    = rd_word;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + ADDR_W'(4);
        end
      end
      S_FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // datapath registers; reset discards any redirect requested in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.PC               = pc_q;
  assign bus.Instruction_Code = instr_q;
  assign bus.instr_pc         = instr_pc_q;
  assign bus.instr_valid      = valid_q;
  assign bus.fault            = fault_q;

endmodule
